// File: rtl/mem_arbiter.sv
// Shared main-memory port arbiter: sequences I/D block fills and D write-through
// onto one multicycle memory port and steers returning words into the caches.
module mem_arbiter #(
    parameter int MEM_LATENCY = 4,
    parameter int WORDS       = 8,
    parameter int ADDR_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_miss,
    input  logic [ADDR_W-1:0]        i_miss_addr,
    input  logic                     d_miss,
    input  logic [ADDR_W-1:0]        d_miss_addr,
    input  logic                     d_wr_req,
    input  logic [ADDR_W-1:0]        d_wr_addr,
    input  logic [15:0]              d_wr_data,
    output logic                     mem_en,
    output logic                     mem_wr,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [15:0]              mem_wdata,
    input  logic                     mem_data_valid,
    output logic                     i_fill_we,
    output logic                     d_fill_we,
    output logic [$clog2(WORDS)-1:0] fill_word,
    output logic                     i_fill_done,
    output logic                     d_fill_done,
    output logic                     d_wr_ack,
    output logic                     i_busy,
    output logic                     d_busy
);

    localparam int IDX_W  = $clog2(WORDS);
    localparam int CNT_W  = IDX_W + 1;
    localparam int BASE_W = ADDR_W - IDX_W - 1;

    typedef enum logic [2:0] {IDLE, WRITE, FILL_I, FILL_D, DONE_I, DONE_D} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    iss_q, iss_d;
    logic [CNT_W-1:0]    rcv_q, rcv_d;
    logic [BASE_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [15:0]         wr_data_q, wr_data_d;

    // Byte-offset bits of miss addresses are irrelevant to a block fill; latency is not timed.
    logic unused_bits;
    assign unused_bits = ^{i_miss_addr[IDX_W:0], d_miss_addr[IDX_W:0], (MEM_LATENCY > 0)};

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= IDLE;
            iss_q     <= '0;
            rcv_q     <= '0;
            base_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            iss_q     <= iss_d;
            rcv_q     <= rcv_d;
            base_q    <= base_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        iss_d       = iss_q;
        rcv_d       = rcv_q;
        base_d      = base_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        i_fill_we   = 1'b0;
        d_fill_we   = 1'b0;
        fill_word   = '0;
        i_fill_done = 1'b0;
        d_fill_done = 1'b0;
        d_wr_ack    = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_miss) begin
                    base_d  = d_miss_addr[ADDR_W-1 -: BASE_W];
                    state_d = FILL_D;
                end else if (d_wr_req) begin
                    wr_addr_d = d_wr_addr;
                    wr_data_d = d_wr_data;
                    state_d   = WRITE;
                end else if (i_miss) begin
                    base_d  = i_miss_addr[ADDR_W-1 -: BASE_W];
                    state_d = FILL_I;
                end
            end
            WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = wr_addr_q;
                mem_wdata = wr_data_q;
                d_wr_ack  = 1'b1;
                state_d   = IDLE;
            end
            FILL_I, FILL_D: begin
                // Issue and receive run independently; only the receive count ends the fill.
                if (iss_q < CNT_W'(WORDS)) begin
                    mem_en   = 1'b1;
                    mem_addr = {base_q, iss_q[IDX_W-1:0], 1'b0};
                    iss_d    = iss_q + 1'b1;
                end
                if (mem_data_valid) begin
                    i_fill_we = (state_q == FILL_I);
                    d_fill_we = (state_q == FILL_D);
                    fill_word = rcv_q[IDX_W-1:0];
                    rcv_d     = rcv_q + 1'b1;
                    if (rcv_q == CNT_W'(WORDS - 1)) begin
                        state_d = (state_q == FILL_I) ? DONE_I : DONE_D;
                    end
                end
            end
            DONE_I: begin
                i_fill_done = 1'b1;
                iss_d       = '0;
                rcv_d       = '0;
                state_d     = IDLE;
            end
            DONE_D: begin
                d_fill_done = 1'b1;
                iss_d       = '0;
                rcv_d       = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        d_busy = (state_q == FILL_D) || (state_q == DONE_D) || (state_q == WRITE)
              || (d_miss && (state_q != DONE_D))
              || (d_wr_req && !d_wr_ack);
        i_busy = (state_q == FILL_I) || (state_q == DONE_I)
              || (i_miss && (state_q != DONE_I));
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester/memory models drive stimulus,
// expected memory issues, fill words and done pulses are queued and checked by a monitor.
module tb_mem_arbiter;

    localparam int WORDS       = 8;
    localparam int MEM_LATENCY = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_miss = 1'b0, d_miss = 1'b0, d_wr_req = 1'b0;
    logic [15:0] i_miss_addr = '0, d_miss_addr = '0, d_wr_addr = '0, d_wr_data = '0;
    logic        mem_en, mem_wr, mem_data_valid = 1'b0;
    logic [15:0] mem_addr, mem_wdata;
    logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, i_busy, d_busy;
    logic [2:0]  fill_word;

    mem_arbiter #(.MEM_LATENCY(MEM_LATENCY), .WORDS(WORDS), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_data_valid(mem_data_valid),
        .i_fill_we(i_fill_we), .d_fill_we(d_fill_we), .fill_word(fill_word),
        .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .d_wr_ack(d_wr_ack),
        .i_busy(i_busy), .d_busy(d_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model: expected transactions ----------------
    typedef struct { logic wr; logic [15:0] addr; logic [15:0] data; int at; } iss_t;
    typedef struct { logic is_d; int word; int at; } fill_t;
    typedef struct { logic is_d; int at; } done_t;

    iss_t  exp_iss[$];
    fill_t exp_fill[$];
    done_t exp_done[$];

    // A block fill requested in an idle cycle t0 reads the 8 halfword-aligned
    // addresses of its 16-byte block on t0+1..t0+8; words return in order.
    task automatic expect_fill(input bit is_d, input logic [15:0] addr, input int t0, input bit timed);
        logic [15:0] base;
        base = addr & 16'hFFF0;
        for (int k = 0; k < WORDS; k++) begin
            exp_iss.push_back('{1'b0, base + 16'(2 * k), 16'h0, t0 + 1 + k});
            exp_fill.push_back('{is_d, k, timed ? t0 + 1 + k + MEM_LATENCY : -1});
        end
        exp_done.push_back('{is_d, timed ? t0 + 1 + WORDS + MEM_LATENCY : -1});
    endtask

    task automatic expect_write(input logic [15:0] addr, input logic [15:0] data, input int at);
        exp_iss.push_back('{1'b1, addr, data, at});
    endtask

    // ---------------- memory model ----------------
    int ret_q[$];
    int last_ret = 0;
    int lat_min = MEM_LATENCY, lat_max = MEM_LATENCY;
    bit stray = 1'b0;

    always @(negedge clk) begin
        int r;
        if (mem_en === 1'b1 && mem_wr === 1'b0) begin
            r = cyc + int'($urandom_range(lat_max, lat_min));
            if (r <= last_ret) r = last_ret + 1;
            last_ret = r;
            ret_q.push_back(r);
        end
    end

    always @(posedge clk) begin
        bit hit;
        #1;
        hit = 1'b0;
        if (ret_q.size() > 0 && ret_q[0] <= cyc) begin
            void'(ret_q.pop_front());
            hit = 1'b1;
        end
        mem_data_valid = hit | stray;
    end

    // ---------------- monitor ----------------
    int last_final = -100;

    always @(negedge clk) begin
        iss_t  ei;
        fill_t ef;
        done_t ed;
        if (cyc > 0) begin
            if (mem_en === 1'b1) begin
                if (exp_iss.size() == 0) begin
                    chk("no_issue_expected", mem_en, 1'b0);
                end else begin
                    ei = exp_iss.pop_front();
                    chk("issue_wr", mem_wr, ei.wr);
                    chk("issue_addr", mem_addr, ei.addr);
                    chk("wr_ack_with_write", d_wr_ack, ei.wr);
                    if (ei.wr) chk("issue_wdata", mem_wdata, ei.data);
                    if (ei.at >= 0) chk("issue_cycle", cyc, ei.at);
                end
            end else begin
                chk("ack_without_issue", d_wr_ack, 1'b0);
            end

            if ((i_fill_we | d_fill_we) === 1'b1) begin
                chk("fill_one_side", i_fill_we & d_fill_we, 1'b0);
                if (exp_fill.size() == 0) begin
                    chk("no_fill_expected", i_fill_we | d_fill_we, 1'b0);
                end else begin
                    ef = exp_fill.pop_front();
                    chk("fill_side", d_fill_we, ef.is_d);
                    chk("fill_word", fill_word, ef.word);
                    if (ef.at >= 0) chk("fill_cycle", cyc, ef.at);
                    if (ef.word == WORDS - 1) last_final = cyc;
                end
            end else begin
                chk("fill_word_idle", fill_word, 3'd0);
            end

            if ((i_fill_done | d_fill_done) === 1'b1) begin
                chk("done_one_side", i_fill_done & d_fill_done, 1'b0);
                if (exp_done.size() == 0) begin
                    chk("no_done_expected", i_fill_done | d_fill_done, 1'b0);
                end else begin
                    ed = exp_done.pop_front();
                    chk("done_side", d_fill_done, ed.is_d);
                    chk("done_after_last_word", cyc, last_final + 1);
                    if (ed.at >= 0) chk("done_cycle", cyc, ed.at);
                end
            end
        end
    end

    // ---------------- requester models ----------------
    task automatic run_miss(input bit is_d, input logic [15:0] addr, input bit check_idle);
        bit got;
        got = 1'b0;
        if (is_d) begin d_miss = 1'b1; d_miss_addr = addr; end
        else      begin i_miss = 1'b1; i_miss_addr = addr; end
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            chk(is_d ? "d_busy_held" : "i_busy_held", is_d ? d_busy : i_busy, 1'b1);
            if ((is_d ? d_fill_done : i_fill_done) === 1'b1) got = 1'b1;
        end
        chk("fill_done_timeout", got, 1'b1);
        @(posedge clk); #1;
        if (is_d) d_miss = 1'b0; else i_miss = 1'b0;
        #1;
        if (check_idle) chk(is_d ? "d_busy_released" : "i_busy_released", is_d ? d_busy : i_busy, 1'b0);
    endtask

    task automatic run_write(input logic [15:0] addr, input logic [15:0] data, input bit check_idle);
        bit got;
        got = 1'b0;
        d_wr_req = 1'b1; d_wr_addr = addr; d_wr_data = data;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            chk("d_busy_wr_held", d_busy, 1'b1);
            if (d_wr_ack === 1'b1) got = 1'b1;
        end
        chk("wr_ack_timeout", got, 1'b1);
        @(posedge clk); #1;
        d_wr_req = 1'b0;
        #1;
        if (check_idle) chk("d_busy_wr_released", d_busy, 1'b0);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_mem"}, {mem_en, mem_wr, mem_addr}, 32'h0);
        chk({tag, "_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_ctrl"}, {i_fill_we, d_fill_we, fill_word, i_fill_done, d_fill_done,
                             d_wr_ack, i_busy, d_busy}, 32'h0);
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic [15:0] a, d;

        // reset
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_quiet("reset");
        gap(2);

        // single D fill, fixed latency
        t0 = cyc;
        expect_fill(1'b1, 16'h1237, t0, 1'b1);
        run_miss(1'b1, 16'h1237, 1'b1);
        chk("d_fill_idle_cycle", cyc, t0 + 14);
        gap(3);

        // simultaneous I and D misses: D wins, I follows after DONE_D + IDLE
        t0 = cyc;
        expect_fill(1'b1, 16'h8000, t0, 1'b1);
        expect_fill(1'b0, 16'h4000, t0 + 14, 1'b1);
        fork
            run_miss(1'b1, 16'h8000, 1'b1);
            run_miss(1'b0, 16'h4000, 1'b1);
        join
        gap(3);

        // write-through with stray valids around it
        t0 = cyc;
        expect_write(16'h00A4, 16'hBEEF, t0 + 1);
        stray = 1'b1;
        run_write(16'h00A4, 16'hBEEF, 1'b1);
        stray = 1'b0;
        gap(3);

        // write request arriving during an I fill waits for IDLE after DONE_I
        t0 = cyc;
        expect_fill(1'b0, 16'h2345, t0, 1'b1);
        expect_write(16'h5550, 16'h1234, t0 + 15);
        fork
            run_miss(1'b0, 16'h2345, 1'b1);
            begin gap(3); run_write(16'h5550, 16'h1234, 1'b1); end
        join
        gap(3);

        // reset during cycle 7 of a D fill aborts it
        t0 = cyc;
        for (int k = 0; k < 7; k++)
            exp_iss.push_back('{1'b0, 16'h1230 + 16'(2 * k), 16'h0, t0 + 1 + k});
        for (int k = 0; k < 3; k++)
            exp_fill.push_back('{1'b1, k, t0 + 5 + k});
        d_miss = 1'b1; d_miss_addr = 16'h1237;
        gap(7);
        rst_n = 1'b1; d_miss = 1'b0;
        gap(1);
        rst_n = 1'b0;
        #1;
        check_quiet("after_abort");
        gap(1);
        stray = 1'b1;
        gap(4);
        stray = 1'b0;
        gap(6);
        t0 = cyc;
        expect_fill(1'b1, 16'h1237, t0, 1'b1);
        run_miss(1'b1, 16'h1237, 1'b1);
        gap(3);

        // randomised memory latency 4..9
        lat_min = 4; lat_max = 9;
        for (int i = 0; i < 3; i++) begin
            t0 = cyc;
            a = 16'($urandom);
            expect_fill(i[0], a, t0, 1'b0);
            run_miss(i[0], a, 1'b1);
            gap(2);
        end

        // random sequence of operations
        for (int i = 0; i < 20; i++) begin
            int op;
            op = int'($urandom_range(2, 0));
            a  = 16'($urandom);
            d  = 16'($urandom);
            t0 = cyc;
            case (op)
                0: begin expect_fill(1'b1, a, t0, 1'b0); run_miss(1'b1, a, 1'b1); end
                1: begin expect_fill(1'b0, a, t0, 1'b0); run_miss(1'b0, a, 1'b1); end
                default: begin expect_write(a, d, t0 + 1); run_write(a, d, 1'b1); end
            endcase
            if ($urandom_range(1, 0) == 1) gap(int'($urandom_range(3, 1)));
        end

        gap(12);
        chk("issues_drained", exp_iss.size(), 0);
        chk("fills_drained", exp_fill.size(), 0);
        chk("dones_drained", exp_done.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the single shared 4-cycle multicycle main-memory port and sequences every access to it.
- Requesters: I-cache miss, D-cache miss, and D-cache write-through.
- On a miss, the block issues the 8 word reads of a 16-byte block on consecutive cycles and counts the returning valid words. It steers each returning word into the requesting cache with a word index, then pulses a per-cache done signal for the tag write.
- Sits between both cache controllers and the memory model; its busy outputs are the pipeline stall sources.

Parameters:
- MEM_LATENCY, 4, cycles from a memory read issue to its data_valid (documentation and bench only; the logic counts valids and does not time them).
- WORDS, 8, 16-bit words per cache block.
- ADDR_W, 16, address width.

Ports:
- clk  in  1  system clock, all state updates on the rising edge
- rst_n  in  1  synchronous, active-high reset (asserted = 1)
- i_miss  in  1  I-cache miss; held by the requester until i_fill_done
- i_miss_addr  in  16  I-cache missing address
- d_miss  in  1  D-cache miss; held by the requester until d_fill_done
- d_miss_addr  in  16  D-cache missing address
- d_wr_req  in  1  D-cache write-through request; held until d_wr_ack
- d_wr_addr  in  16  write address
- d_wr_data  in  16  write data
- mem_en  out  1  memory access enable
- mem_wr  out  1  memory write (1) / read (0)
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_data_valid  in  1  memory read data valid this cycle
- i_fill_we  out  1  write the returning word into the I-cache data array
- d_fill_we  out  1  write the returning word into the D-cache data array
- fill_word  out  3  word index of the returning word
- i_fill_done  out  1  one-cycle pulse: I-cache block complete, write tag/valid
- d_fill_done  out  1  one-cycle pulse: D-cache block complete
- d_wr_ack  out  1  one-cycle pulse: write issued to memory
- i_busy  out  1  I-side stall
- d_busy  out  1  D-side stall

Behaviour:
- States: IDLE, WRITE, FILL_I, FILL_D, DONE_I, DONE_D. Registers:
  - 3-bit state
  - 4-bit issue counter iss
  - 4-bit receive counter rcv
  - 12-bit block base (tag+index)
  - 16-bit write address and write data
- Reset (rst_n=1 at an edge):
  - State returns to IDLE; iss and rcv clear to 0.
  - All outputs are 0 while in IDLE with no request present.
  - Reset mid-fill or mid-write aborts the operation with no done or ack pulse.
- IDLE arbitration, fixed priority d_miss > d_wr_req > i_miss:
  - d_miss: latch d_miss_addr[15:4] as the base, go to FILL_D.
  - Else d_wr_req: latch d_wr_addr and d_wr_data, go to WRITE.
  - Else i_miss: latch i_miss_addr[15:4] as the base, go to FILL_I.
  - IDLE itself issues nothing (mem_en=0).
- WRITE (1 cycle):
  - Outputs: mem_en=1, mem_wr=1, mem_addr and mem_wdata from the latched values, d_wr_ack=1.
  - Next state is IDLE.
- FILL_x issue phase:
  - While iss<8: mem_en=1, mem_wr=0, mem_addr={base,iss[2:0],1'b0}, and iss increments by 1 each cycle.
  - Addresses therefore run base|0x0 to base|0xE on 8 consecutive cycles.
  - Once iss=8: mem_en=0.
- FILL_x receive:
  - Each cycle with mem_data_valid=1, x_fill_we=1 (combinational from mem_data_valid), fill_word=rcv[2:0], and rcv increments by 1.
  - Issue and receive proceed concurrently.
  - When mem_data_valid=1 with rcv=7: go to DONE_x.
- DONE_x (1 cycle): x_fill_done=1; iss and rcv clear; next state is IDLE.
- Busy outputs:
  - d_busy = (state in {FILL_D, DONE_D, WRITE}) | (d_miss & state!=DONE_D) | (d_wr_req & !d_wr_ack).
  - i_busy = (state in {FILL_I, DONE_I}) | (i_miss & state!=DONE_I).
  - Busy drops the cycle after done.
- Fill_word when no fill write is active: fill_word=0 whenever both i_fill_we and d_fill_we are 0.
- Edge cases:
  - mem_data_valid in IDLE or WRITE: ignored, with no fill_we.
  - Miss deasserted mid-fill: the fill still completes.
  - A request arriving during another operation waits. It is arbitrated in the first IDLE cycle after DONE_x or WRITE.
  - I-side starvation is possible by design. Write-through bursts are bounded by the pipeline.
- Fill latency with MEM_LATENCY=4 (issue n returns at n+4):
  - Miss seen in IDLE at cycle 0.
  - Issues at cycles 1–8.
  - Valids at cycles 5–12.
  - done at cycle 13.
  - IDLE at cycle 14.

Test Plan:
- Reset, then d_miss=1 with d_miss_addr=0x1237 at cycle 0 → mem_addr 0x1230, 0x1232 … 0x123E on cycles 1–8 with mem_en=1; d_fill_we at cycles 5–12 with fill_word 0–7; d_fill_done at cycle 13 only; d_busy=0 at cycle 14.
- i_miss and d_miss rise together (addresses 0x4000 and 0x8000) → D fill runs first (0x8000–0x800E); I issues begin the cycle after DONE_D+IDLE; i_busy stays 1 throughout; i_fill_done pulses exactly once.
- d_wr_req with d_wr_addr=0x00A4 and d_wr_data=0xBEEF in IDLE → next cycle mem_en=1, mem_wr=1, mem_addr=0x00A4, mem_wdata=0xBEEF, d_wr_ack=1; IDLE the following cycle.
- d_wr_req asserted during an I fill → no write issued until i_fill_done; write is issued in WRITE 2 cycles later; I fill data is unaffected.
- rst_n pulsed at cycle 7 of a D fill → IDLE at the next edge; no d_fill_done; stray mem_data_valid pulses afterwards produce no fill_we; a subsequent d_miss restarts at word 0.
- Bench memory with randomised valid gaps (latency 4–9) → 8 fill_we pulses with fill_word 0–7 in order; done follows the 8th valid by 1 cycle.
